vga_pixel_sink: RTL and testbench

// - Pixel-write responder for all game drawers (paddle, ball, bricks), which emit x/y/color plot requests.
// - Buffers requests in a small FIFO and converts each to a linear framebuffer address.
// - Issues one write per cycle to the 160x120, 3-bit-colour video memory port.
// - Provides a full-screen clear sweep to black, with back-pressure to drawers while clearing.

---
 rtl/vga_pixel_sink_pkg.sv | 35 +++
 rtl/vga_pixel_sink_pixel_fifo.sv | 44 ++++
 rtl/vga_pixel_sink.sv | 124 ++++++++++++
 tb/tb_vga_pixel_sink.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pixel_sink_pkg.sv
// Shared screen geometry, framebuffer widths and sink types.
// Pure definitions; no latency.
// No flow control; used by the sink and its FIFO.
package game_defs;

    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int FB_ADDR_W = 15;
    localparam int COLOR_W   = 3;
    localparam int FIFO_W    = 22;

    localparam logic [COLOR_W-1:0]   COLOR_BLACK = 3'b000;
    localparam logic [FB_ADDR_W-1:0] LAST_ADDR   = FB_ADDR_W'(SCREEN_W * SCREEN_H - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // One buffered plot: linear address plus colour, padded to the FIFO width.
    typedef struct packed {
        logic [3:0]           spare;
        logic [COLOR_W-1:0]   color;
        logic [FB_ADDR_W-1:0] addr;
    } pix_t;

    // y*160 + x as two shifts and an add, held at full 15-bit width.
    function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
        logic [FB_ADDR_W-1:0] yw;
        yw = {8'd0, y};
        return (yw << 7) + (yw << 5) + {7'd0, x};
    endfunction

endpackage

// File: rtl/vga_pixel_sink_pixel_fifo.sv
// Synchronous FIFO for plot requests, pointer-MSB wrap detection.
// Write visible on dout the cycle after push; dout shows head combinationally.
// push ignored when full, pop ignored when empty; caller gates with full/empty.
module pixel_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/vga_pixel_sink.sv
// Plot-request sink: range check, address calc, FIFO, one framebuffer write/cycle, clear sweep.
// Accept at edge N into empty FIFO gives mem_wren one edge later (N+1).
// plot_ready drops when FIFO full or during flush/clear; off-screen plots still handshake.
module vga_pixel_sink
    import game_defs::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 plot_valid,
    input  logic [7:0]           x_in,
    input  logic [6:0]           y_in,
    input  logic [COLOR_W-1:0]   color_in,
    output logic                 plot_ready,
    input  logic                 clear_req,
    output logic                 clear_busy,
    output logic                 clear_done,
    output logic [FB_ADDR_W-1:0] mem_addr,
    output logic [COLOR_W-1:0]   mem_data,
    output logic                 mem_wren,
    output logic [7:0]           drop_count
);

    localparam logic [7:0] X_LIMIT = 8'(SCREEN_W);
    localparam logic [6:0] Y_LIMIT = 7'(SCREEN_H);

    state_t               state;
    state_t               state_nxt;
    logic [FB_ADDR_W-1:0] clr_cnt;
    pix_t                 fifo_din;
    pix_t                 fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 on_screen;
    logic                 accept;
    logic                 last_clear;
    logic                 spare_unused;

    assign on_screen  = (x_in < X_LIMIT) && (y_in < Y_LIMIT);
    assign plot_ready = resetn && (state == ST_RUN) && !fifo_full;
    assign accept     = plot_valid && plot_ready;
    assign fifo_push  = accept && on_screen;
    assign fifo_pop   = ((state == ST_RUN) || (state == ST_FLUSH)) && !fifo_empty;
    assign last_clear = (state == ST_CLEAR) && (clr_cnt == LAST_ADDR);
    assign clear_busy = (state != ST_RUN);

    assign fifo_din     = '{spare: 4'd0, color: color_in, addr: fb_addr(x_in, y_in)};
    assign spare_unused = ^fifo_dout.spare;

    pixel_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .din    (fifo_din),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Next-state: RUN -> FLUSH on clear, FLUSH -> CLEAR once drained, CLEAR -> RUN after last pixel.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (clear_req)  state_nxt = ST_FLUSH;
            ST_FLUSH: if (fifo_empty) state_nxt = ST_CLEAR;
            ST_CLEAR: if (last_clear) state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // State register; reset anywhere, including mid-sweep, returns to RUN.
    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_RUN;
        else         state <= state_nxt;
    end

    // Clear sweep counter: parked at zero while flushing, steps once per CLEAR cycle.
    always_ff @(posedge clk) begin
        if (!resetn)                 clr_cnt <= '0;
        else if (state == ST_FLUSH)  clr_cnt <= '0;
        else if (state == ST_CLEAR)  clr_cnt <= clr_cnt + 1'b1;
    end

    // Memory port: clear pixel wins, else FIFO head, else idle holding last addr/data.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_addr <= '0;
            mem_data <= '0;
            mem_wren <= 1'b0;
        end else if (state == ST_CLEAR) begin
            mem_addr <= clr_cnt;
            mem_data <= COLOR_BLACK;
            mem_wren <= 1'b1;
        end else if (fifo_pop) begin
            mem_addr <= fifo_dout.addr;
            mem_data <= fifo_dout.color;
            mem_wren <= 1'b1;
        end else begin
            mem_wren <= 1'b0;
        end
    end

    // Completion pulse, high alongside the final sweep write.
    always_ff @(posedge clk) begin
        if (!resetn) clear_done <= 1'b0;
        else         clear_done <= last_clear;
    end

    // Saturating count of handshaken off-screen plots.
    always_ff @(posedge clk) begin
        if (!resetn)
            drop_count <= '0;
        else if (accept && !on_screen && (drop_count != 8'hFF))
            drop_count <= drop_count + 8'd1;
    end

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Directed + random bench for vga_pixel_sink against a queue-based reference model.
// Writes are collected by a monitor and compared in order with expected y*160+x.
// Clear sweeps are checked for full ordered coverage and a single done pulse.
module tb_vga_pixel_sink;

    logic        clk;
    logic        resetn;
    logic        plot_valid;
    logic [7:0]  x_in;
    logic [6:0]  y_in;
    logic [2:0]  color_in;
    logic        plot_ready;
    logic        clear_req;
    logic        clear_busy;
    logic        clear_done;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_wren;
    logic [7:0]  drop_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_q[$];
    int got_q[$];
    int got_t[$];
    int exp_drop = 0;
    int done_cnt = 0;
    int rdy_viol = 0;
    int stalls   = 0;
    int cyc      = 0;

    vga_pixel_sink #(.FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .plot_valid (plot_valid),
        .x_in       (x_in),
        .y_in       (y_in),
        .color_in   (color_in),
        .plot_ready (plot_ready),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write, every done pulse, and any ready-while-busy cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mem_wren) begin
            got_q.push_back(int'(mem_addr) * 8 + int'(mem_data));
            got_t.push_back(cyc);
        end
        if (clear_done) done_cnt++;
        if (clear_busy && plot_ready) rdy_viol++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one plot, hold until accepted, then update the reference model.
    task automatic plot(input int x, input int y, input int c, input bit clr);
        int waitc = 0;
        @(negedge clk);
        plot_valid = 1'b1;
        x_in       = 8'(x);
        y_in       = 7'(y);
        color_in   = 3'(c);
        clear_req  = clr;
        #1;
        while (!plot_ready && waitc < 100) begin
            stalls++;
            waitc++;
            @(negedge clk);
            #1;
        end
        if (waitc >= 100) chk("plot_timeout", waitc, 0);
        @(posedge clk);
        if (x < 160 && y < 120) exp_q.push_back((y * 160 + x) * 8 + c);
        else if (exp_drop < 255) exp_drop++;
    endtask

    task automatic idle();
        @(negedge clk);
        plot_valid = 1'b0;
        clear_req  = 1'b0;
    endtask

    task automatic compare_q(input string tag);
        int nbad = 0;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] != exp_q[i]) nbad++;
        chk({tag, "_content"}, nbad, 0);
        got_q.delete();
        got_t.delete();
        exp_q.delete();
    endtask

    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 25000; k++) begin
            @(negedge clk);
            if (clear_done) break;
        end
        if (k >= 25000) chk({tag, "_timeout"}, k, 0);
    endtask

    initial begin
        resetn     = 1'b0;
        plot_valid = 1'b0;
        x_in       = '0;
        y_in       = '0;
        color_in   = '0;
        clear_req  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_plot_ready", int'(plot_ready), 0);
        chk("rst_mem_wren",   int'(mem_wren),   0);
        chk("rst_mem_addr",   int'(mem_addr),   0);
        chk("rst_drop_count", int'(drop_count), 0);
        chk("rst_clear_busy", int'(clear_busy), 0);
        chk("rst_clear_done", int'(clear_done), 0);
        resetn = 1'b1;
        #1;
        chk("post_rst_ready", int'(plot_ready), 1);
        @(negedge clk);
        got_q.delete();
        got_t.delete();

        // Single pixel latency: accept at edge N, write visible after edge N+1
        @(negedge clk);
        plot_valid = 1'b1;
        x_in = 8'd75; y_in = 7'd110; color_in = 3'd7;
        #1;
        chk("single_ready", int'(plot_ready), 1);
        @(posedge clk);
        @(negedge clk);
        plot_valid = 1'b0;
        chk("single_wren_n", int'(mem_wren), 0);
        @(negedge clk);
        chk("single_wren_n1", int'(mem_wren), 1);
        chk("single_addr", int'(mem_addr), 75 + 110 * 160);
        chk("single_data", int'(mem_data), 7);
        @(negedge clk);
        chk("single_wren_after", int'(mem_wren), 0);
        repeat (2) @(negedge clk);
        chk("single_write_count", got_q.size(), 1);
        got_q.delete();
        got_t.delete();

        // Off-screen requests are handshaken and counted, never written
        stalls = 0;
        plot(160, 5, 1, 1'b0);
        plot(3, 120, 2, 1'b0);
        idle();
        repeat (5) @(negedge clk);
        chk("offscreen_drop", int'(drop_count), exp_drop);
        chk("offscreen_writes", got_q.size(), 0);
        chk("offscreen_stalls", stalls, 0);

        // Back-to-back row of 16
        stalls = 0;
        for (int i = 0; i < 16; i++) plot(i, 0, i % 8, 1'b0);
        idle();
        repeat (5) @(negedge clk);
        begin
            int gaps = 0;
            for (int i = 1; i < got_t.size(); i++)
                if (got_t[i] != got_t[i-1] + 1) gaps++;
            chk("b2b_spacing", gaps, 0);
        end
        chk("b2b_stalls", stalls, 0);
        compare_q("b2b");

        // Randomized mix of on/off-screen plots with random idle gaps
        for (int i = 0; i < 300; i++) begin
            plot(int'($urandom_range(0, 175)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 7)), 1'b0);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        repeat (10) @(negedge clk);
        compare_q("random");
        chk("random_drop", int'(drop_count), exp_drop);

        // Saturate the drop counter
        for (int i = 0; i < 260; i++) begin
            if (i % 2 == 0) plot(int'($urandom_range(160, 255)), int'($urandom_range(0, 127)), 0, 1'b0);
            else            plot(int'($urandom_range(0, 255)), int'($urandom_range(120, 127)), 0, 1'b0);
        end
        idle();
        repeat (3) @(negedge clk);
        chk("drop_saturate", int'(drop_count), exp_drop);
        chk("drop_saturate_abs", int'(drop_count), 255);
        got_q.delete();
        got_t.delete();

        // Clear with pending pixels; the fifth arrives alongside clear_req
        done_cnt = 0;
        rdy_viol = 0;
        for (int i = 0; i < 4; i++)
            plot(int'($urandom_range(0, 159)), int'($urandom_range(0, 119)), int'($urandom_range(1, 7)), 1'b0);
        plot(int'($urandom_range(0, 159)), int'($urandom_range(0, 119)), int'($urandom_range(1, 7)), 1'b1);
        idle();
        wait_done("clear1");
        #1;
        chk("clear1_ready_back", int'(plot_ready), 1);
        chk("clear1_busy_low", int'(clear_busy), 0);
        for (int i = 0; i < 19200; i++) exp_q.push_back(i * 8);
        repeat (10) @(negedge clk);
        compare_q("clear1");
        chk("clear1_done_pulses", done_cnt, 1);
        chk("clear1_ready_while_busy", rdy_viol, 0);

        // Second clear_req during CLEAR must not restart or extend the sweep
        done_cnt = 0;
        @(negedge clk);
        clear_req = 1'b1;
        idle();
        repeat (1000) @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        wait_done("clear2");
        repeat (40) @(negedge clk);
        for (int i = 0; i < 19200; i++) exp_q.push_back(i * 8);
        compare_q("clear2");
        chk("clear2_done_pulses", done_cnt, 1);

        // Reset with the clear counter at 500 aborts the sweep silently
        done_cnt = 0;
        @(negedge clk);
        clear_req = 1'b1;
        idle();
        begin
            int k;
            for (k = 0; k < 2000; k++) begin
                @(negedge clk);
                if (mem_wren && int'(mem_addr) == 499 && clear_busy) break;
            end
            if (k >= 2000) chk("midreset_reach_timeout", k, 0);
        end
        resetn = 1'b0;
        @(negedge clk);
        chk("midreset_wren", int'(mem_wren), 0);
        chk("midreset_busy", int'(clear_busy), 0);
        chk("midreset_ready_low", int'(plot_ready), 0);
        chk("midreset_drop", int'(drop_count), 0);
        exp_drop = 0;
        resetn = 1'b1;
        #1;
        chk("midreset_ready_back", int'(plot_ready), 1);
        got_q.delete();
        got_t.delete();
        exp_q.delete();
        repeat (40) @(negedge clk);
        chk("midreset_no_done", done_cnt, 0);
        chk("midreset_no_writes", got_q.size(), 0);

        // Normal operation resumes after reset
        plot(10, 10, 5, 1'b0);
        plot(159, 119, 3, 1'b0);
        idle();
        repeat (5) @(negedge clk);
        compare_q("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
